// File: rtl/hidden_spike_arbiter.sv
// Round-robin arbiter turning hidden-neuron spike requests into address events.
// Latency: request sampled at E0 -> one-cycle ack after E0 -> aer_valid from E1; one event per 3 cycles peak.
// Backpressure: aer_valid/aer_addr held in SEND until aer_ready; spike_req is not sampled while busy.
//
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   spike_req          level request per neuron, held until acknowledged
//   spike_ack          registered one-hot, single-cycle acknowledge to the winner
//   aer_valid/ready    address-event handshake toward the next layer
//   aer_addr           (ADDR_BASE + winner) mod 256, stable while aer_valid
//   count_clr          synchronous clear of event_count (wins over increment)
//   event_count        events accepted since reset/clear, wraps at 2^CNT_W
//   busy               state != IDLE
module hidden_spike_arbiter #(
    parameter int         N_NEURONS = 32,
    parameter logic [7:0] ADDR_BASE = 8'd0,
    parameter int         CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_NEURONS-1:0] spike_req,
    output logic [N_NEURONS-1:0] spike_ack,
    output logic                 aer_valid,
    input  logic                 aer_ready,
    output logic [7:0]           aer_addr,
    input  logic                 count_clr,
    output logic [CNT_W-1:0]     event_count,
    output logic                 busy
);

    localparam int IDX_W = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    // one extra bit so ptr + offset cannot overflow before the wrap correction
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt;
    logic [IDX_W-1:0]       idx, idx_nxt;
    logic [N_NEURONS-1:0]   ack_nxt;
    logic                   valid_nxt;
    logic [7:0]             addr_nxt;
    logic [CNT_W-1:0]       count_nxt;

    logic [2*N_NEURONS-1:0] req_dbl;
    logic [N_NEURONS-1:0]   req_rot;
    logic [SUM_W-1:0]       off;
    logic [SUM_W-1:0]       sum;
    logic [IDX_W-1:0]       win;
    logic                   found;
    logic                   accept;

    // Rotate the request vector so index ptr lands at bit 0; the lowest set
    // bit of the rotated vector is then the round-robin winner's distance
    // from ptr. Doubling the vector makes the rotation a plain part-select.
    assign req_dbl = {spike_req, spike_req};
    assign req_rot = req_dbl[ptr +: N_NEURONS];
    assign found   = |spike_req;

    always_comb begin
        off = '0;
        for (int i = N_NEURONS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off = SUM_W'(i);
            end
        end
    end

    assign sum = {1'b0, ptr} + off;
    assign win = (sum >= SUM_W'(N_NEURONS)) ? IDX_W'(sum - SUM_W'(N_NEURONS))
                                            : IDX_W'(sum);

    assign accept = (state == SEND) && aer_valid && aer_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = idx;
        ack_nxt   = '0;
        valid_nxt = aer_valid;
        addr_nxt  = aer_addr;
        count_nxt = event_count;

        case (state)
            IDLE: begin
                if (found) begin
                    idx_nxt      = win;
                    ack_nxt[win] = 1'b1;
                    addr_nxt     = ADDR_BASE + 8'(win);
                    state_nxt    = ACK;
                end
            end
            ACK: begin
                valid_nxt = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (aer_valid && aer_ready) begin
                    valid_nxt = 1'b0;
                    ptr_nxt   = (idx == IDX_W'(N_NEURONS - 1)) ? '0 : idx + IDX_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (count_clr) begin
            count_nxt = '0;
        end else if (accept) begin
            count_nxt = event_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            ptr         <= '0;
            idx         <= '0;
            spike_ack   <= '0;
            aer_valid   <= 1'b0;
            aer_addr    <= 8'd0;
            event_count <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            idx         <= idx_nxt;
            spike_ack   <= ack_nxt;
            aer_valid   <= valid_nxt;
            aer_addr    <= addr_nxt;
            event_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_hidden_spike_arbiter.sv
// Testbench for hidden_spike_arbiter: neuron models drive requests, a monitor predicts grants.
// Latency: predictions follow the E0 grant / E1 valid / handshake-to-idle timing of the block.
// Backpressure: aer_ready is held low in directed cases and randomized elsewhere.
module tb_hidden_spike_arbiter;

    localparam int         N    = 32;
    localparam logic [7:0] BASE = 8'd250;
    localparam int         CW   = 4;

    logic          clk;
    logic          resetn;
    logic [N-1:0]  spike_req;
    logic [N-1:0]  spike_ack;
    logic          aer_valid;
    logic          aer_ready;
    logic [7:0]    aer_addr;
    logic          count_clr;
    logic [CW-1:0] event_count;
    logic          busy;

    hidden_spike_arbiter #(
        .N_NEURONS (N),
        .ADDR_BASE (BASE),
        .CNT_W     (CW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .spike_req   (spike_req),
        .spike_ack   (spike_ack),
        .aer_valid   (aer_valid),
        .aer_ready   (aer_ready),
        .aer_addr    (aer_addr),
        .count_clr   (count_clr),
        .event_count (event_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [7:0]    exp_q[$];
    int            grant_log[$];
    int            model_ptr = 0;
    logic [CW-1:0] exp_count = '0;
    logic [N-1:0]  req_hist  = '0;
    bit            rst_pend  = 1'b0;
    bit            started   = 1'b0;
    bit            m_ack     = 1'b0;
    bit            m_valid   = 1'b0;
    bit            m_ready   = 1'b0;
    bit            m_busy    = 1'b0;
    logic [7:0]    m_addr    = 8'd0;

    // first requester at or after p, wrapping round the neuron array
    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        int j;
        for (int i = 0; i < N; i++) begin
            j = (p + i) % N;
            if (r[j]) return j;
        end
        return 0;
    endfunction

    // request vector as seen by each rising edge
    always @(posedge clk) req_hist <= spike_req;

    always @(negedge clk) begin
        int           w;
        logic [N-1:0] e_ack;
        logic         e_valid;
        logic [7:0]   exp_addr;
        e_ack   = '0;
        e_valid = 1'b0;
        if (rst_pend) begin
            chk(spike_ack == '0, "rst_ack", spike_ack, 0);
            chk(aer_valid == 1'b0, "rst_valid", aer_valid, 0);
            chk(aer_addr == 8'd0, "rst_addr", aer_addr, 0);
            chk(event_count == '0, "rst_count", event_count, 0);
            chk(busy == 1'b0, "rst_busy", busy, 0);
            exp_q.delete();
            model_ptr = 0;
            exp_count = '0;
            started   = 1'b1;
        end else if (started) begin
            if (!m_busy && req_hist != '0) begin
                w        = rr_pick(req_hist, model_ptr);
                e_ack[w] = 1'b1;
                exp_q.push_back(8'((int'(BASE) + w) % 256));
                grant_log.push_back(w);
                model_ptr = (w + 1) % N;
            end
            e_valid = m_ack || (m_valid && !m_ready);
            chk(spike_ack == e_ack, "ack", spike_ack, e_ack);
            chk(aer_valid == e_valid, "aer_valid", aer_valid, e_valid);
            chk(busy == ((e_ack != '0) || e_valid), "busy", busy, (e_ack != '0) || e_valid);
            chk(event_count == exp_count, "event_count", event_count, exp_count);
            if (e_valid && m_valid) begin
                chk(aer_addr == m_addr, "addr_stable", aer_addr, m_addr);
            end
            if (aer_valid && aer_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_event", aer_addr, 0);
                end else begin
                    exp_addr = exp_q.pop_front();
                    chk(aer_addr == exp_addr, "event_addr", aer_addr, exp_addr);
                end
            end
        end
        if (started) begin
            if (count_clr) exp_count = '0;
            else if (e_valid && aer_ready) exp_count = exp_count + CW'(1);
        end
        m_ack    = (e_ack != '0);
        m_valid  = e_valid;
        m_ready  = aer_ready;
        m_addr   = aer_addr;
        m_busy   = (e_ack != '0) || e_valid;
        rst_pend = !resetn;
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] keep_mask;

    // advance one cycle; neurons drop their request on the edge after their ack
    // unless a new spike (keep_mask) keeps it high
    task automatic step();
        logic [N-1:0] a;
        a = spike_ack;
        @(posedge clk);
        #1;
        spike_req = spike_req & ~(a & ~keep_mask);
    endtask

    task automatic do_reset(input int n);
        resetn = 1'b0;
        repeat (n) step();
        resetn = 1'b1;
    endtask

    task automatic wait_valid(input int max, input string name);
        int n;
        n = 0;
        while (!aer_valid && n < max) begin
            step();
            n++;
        end
        chk(aer_valid == 1'b1, name, aer_valid, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int           g0;
        int           bc;
        int           vcnt;
        int           acks;
        int           n;
        int           order[3];
        logic [N-1:0] oh;

        resetn    = 1'b0;
        spike_req = '0;
        aer_ready = 1'b0;
        count_clr = 1'b0;
        keep_mask = '0;
        repeat (3) step();
        resetn = 1'b1;
        chk(spike_ack == '0, "reset_ack", spike_ack, 0);
        chk(aer_valid == 1'b0, "reset_valid", aer_valid, 0);
        chk(aer_addr == 8'd0, "reset_addr", aer_addr, 0);
        chk(event_count == '0, "reset_count", event_count, 0);
        chk(busy == 1'b0, "reset_busy", busy, 0);

        // single request: busy for exactly ack + send cycles
        aer_ready    = 1'b1;
        spike_req[5] = 1'b1;
        g0 = grant_log.size();
        bc = 0;
        repeat (6) begin
            step();
            if (busy) bc++;
        end
        chk(bc == 2, "single_busy_cycles", bc, 2);
        chk(grant_log.size() == g0 + 1, "single_grants", grant_log.size() - g0, 1);
        if (grant_log.size() > g0) chk(grant_log[g0] == 5, "single_winner", grant_log[g0], 5);
        chk(event_count == CW'(1), "single_count", event_count, 1);

        // round robin from a fresh pointer, then wrap back to 2
        do_reset(2);
        order = '{2, 7, 30};
        spike_req[2]  = 1'b1;
        spike_req[7]  = 1'b1;
        spike_req[30] = 1'b1;
        g0 = grant_log.size();
        repeat (15) step();
        chk(grant_log.size() == g0 + 3, "rr_grants", grant_log.size() - g0, 3);
        for (int k = 0; k < 3; k++) begin
            if (grant_log.size() > g0 + k) chk(grant_log[g0 + k] == order[k], "rr_order", grant_log[g0 + k], order[k]);
        end
        spike_req[2] = 1'b1;
        g0 = grant_log.size();
        repeat (6) step();
        if (grant_log.size() > g0) chk(grant_log[g0] == 2, "rr_wrap", grant_log[g0], 2);
        else chk(1'b0, "rr_wrap_missing", 0, 2);

        // backpressure: ready low for the first 10 valid cycles
        count_clr = 1'b1;
        step();
        count_clr    = 1'b0;
        aer_ready    = 1'b0;
        spike_req[3] = 1'b1;
        vcnt = 0;
        acks = 0;
        n    = 0;
        while (!(vcnt >= 11 && !aer_valid) && n < 40) begin
            step();
            n++;
            if (spike_ack != '0) acks++;
            if (aer_valid) vcnt++;
            if (vcnt == 11) aer_ready = 1'b1;
        end
        chk(vcnt == 11, "bp_valid_cycles", vcnt, 11);
        chk(acks == 1, "bp_acks", acks, 1);
        chk(event_count == CW'(1), "bp_count", event_count, 1);

        // address wraps modulo 256: 250 + 10 -> 4
        aer_ready     = 1'b0;
        spike_req[10] = 1'b1;
        wait_valid(6, "wrap_wait");
        chk(aer_addr == 8'd4, "addr_wrap", aer_addr, 4);
        aer_ready = 1'b1;
        repeat (3) step();

        // reset while an event is pending; request 1 stays high through it
        aer_ready    = 1'b0;
        keep_mask[1] = 1'b1;
        spike_req[1] = 1'b1;
        wait_valid(6, "midsend_wait");
        resetn = 1'b0;
        step();
        chk(spike_ack == '0, "midsend_ack", spike_ack, 0);
        chk(aer_valid == 1'b0, "midsend_valid", aer_valid, 0);
        chk(aer_addr == 8'd0, "midsend_addr", aer_addr, 0);
        chk(event_count == '0, "midsend_count", event_count, 0);
        resetn = 1'b1;
        step();
        oh    = '0;
        oh[1] = 1'b1;
        chk(spike_ack == oh, "post_reset_ack", spike_ack, oh);
        keep_mask = '0;
        aer_ready = 1'b1;
        repeat (4) step();

        // clear on a handshake edge wins over the increment
        spike_req[4] = 1'b1;
        wait_valid(6, "clr_wait");
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        chk(event_count == '0, "clr_priority", event_count, 0);
        repeat (2) step();

        // 17 events with a 4-bit counter
        count_clr = 1'b1;
        step();
        count_clr = 1'b0;
        for (int k = 0; k < 17; k++) begin
            spike_req[k] = 1'b1;
            repeat (4) step();
        end
        chk(event_count == CW'(1), "count_wrap", event_count, 1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int b = 0; b < N; b++) begin
                if (!spike_req[b] && !spike_ack[b] && $urandom_range(0, 15) == 0) spike_req[b] = 1'b1;
            end
            keep_mask = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            aer_ready = ($urandom_range(0, 2) != 0);
            count_clr = ($urandom_range(0, 63) == 0);
            resetn    = ($urandom_range(0, 399) != 0);
        end

        // drain
        resetn    = 1'b1;
        count_clr = 1'b0;
        keep_mask = '0;
        aer_ready = 1'b1;
        n = 0;
        while ((spike_req != '0 || busy) && n < 500) begin
            step();
            n++;
        end
        chk(spike_req == '0 && !busy, "drain", {spike_req, busy}, 0);
        repeat (2) step();
        chk(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hidden_spike_arbiter.md
HIDDEN_SPIKE_ARBITER -- requirements
Module: hidden_spike_arbiter

Interface
REQ-001 Parameter N_NEURONS, default 32, number of hidden neurons served, legal range 1..256.
REQ-002 Parameter ADDR_BASE, default 8'd0, offset added to the winning index to form the event address.
REQ-003 Parameter CNT_W, default 16, width of event_count.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 resetn  input  1  reset, synchronous, active-low.
REQ-006 spike_req  input  N_NEURONS  level request per neuron (a neuron's spike_out); held high until acknowledged.
REQ-007 spike_ack  output  N_NEURONS  one-hot, single-cycle acknowledge to the granted neuron (drives its ack_in).
REQ-008 aer_valid  output  1  address-event valid toward the next layer.
REQ-009 aer_ready  input  1  next layer accepts the event when high together with aer_valid.
REQ-010 aer_addr  output  8  event address; stable while aer_valid is high.
REQ-011 count_clr  input  1  synchronous clear of event_count.
REQ-012 event_count  output  CNT_W  number of events accepted since reset or clear.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, ACK, SEND.
REQ-015 IDLE, no bit of spike_req set -> stay in IDLE; all outputs hold their idle values.
REQ-016 IDLE, any request set -> select a winner by round-robin, searching from index ptr upward with wrap at N_NEURONS-1 -> 0.
REQ-017 On that same edge: latch the winner as idx, set spike_ack[idx]=1 (registered), load aer_addr = (ADDR_BASE + idx) mod 256, and go to ACK.
REQ-018 ACK -> SEND unconditionally on the next edge; spike_ack returns to all-zero and aer_valid is set to 1.
REQ-019 spike_ack SHALL therefore be high for exactly one cycle per grant and never have more than one bit set.
REQ-020 SEND: hold aer_valid=1 and a constant aer_addr until an edge samples aer_valid & aer_ready.
REQ-021 On that handshake edge: set aer_valid=0, increment event_count, set ptr = (idx+1) mod N_NEURONS, go to IDLE.
REQ-022 Minimum latency: request sampled at edge E0 -> ack high in cycle E0..E1 -> aer_valid high from E1; peak throughput is one event per 3 cycles.
REQ-023 spike_req is never sampled in ACK or SEND; a neuron clears its request on the edge after its ack, so it is not re-granted spuriously.
REQ-024 A request that stays high after the ack cycle (a new spike) SHALL be served as a new event in round-robin order.
REQ-025 event_count wraps modulo 2^CNT_W.
REQ-026 count_clr forces event_count to 0 and takes priority over a simultaneous increment.
REQ-027 aer_ready while aer_valid is low SHALL be ignored.
REQ-028 busy = (state != IDLE), decoded from registered state.

Reset
REQ-029 resetn low at an edge SHALL set: state IDLE, spike_ack=0, aer_valid=0, aer_addr=0, event_count=0, ptr=0, idx=0, from any state including mid-SEND.
REQ-030 An event pending in SEND during reset SHALL be dropped and not counted.
REQ-031 Arbitration resumes on the first edge with resetn high.

Verification
REQ-032 Single request: req[5]=1 with aer_ready=1 -> ack[5] high exactly one cycle; aer_valid high one cycle later with aer_addr=5; event_count=1; busy high for 2 cycles.
REQ-033 Round-robin: req[2], req[7] and req[30] all high, each neuron clearing on its ack -> grant order 2, 7, 30; then, with only req[2] high again, 2 is granted (wrap).
REQ-034 Backpressure: req[3] high, aer_ready low for 10 cycles then high -> aer_valid and aer_addr=3 held stable for 11 cycles; no further ack issued; exactly one count.
REQ-035 Address wrap: ADDR_BASE=8'd250, N_NEURONS=32, req[10] -> aer_addr=4.
REQ-036 Reset mid-SEND: resetn low while aer_valid=1 -> next cycle all outputs 0 and event_count=0; req[1] still high after release -> ack[1] one cycle later.
REQ-037 Counter: count_clr asserted on a handshake edge -> event_count=0; CNT_W=4 with 17 events -> event_count=1.
